mat_row_unpack: RTL and testbench



---
 rtl/mat_row_unpack_if.sv | 26 ++
 rtl/mat_row_unpack.sv | 86 ++++++++
 tb/tb_mat_row_unpack.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mat_row_unpack_if.sv
// Bus between the read-address sequencer, the row unpacker and the multiply array.
interface mat_row_unpack_if #(
  parameter int ELEM_W  = 16,
  parameter int ROW_LEN = 32
);
  logic                      data_valid;
  logic                      sel_upper;
  logic [2*ELEM_W-1:0]       rdata;
  logic                      row_ready;
  logic                      row_valid;
  logic [ROW_LEN*ELEM_W-1:0] row_data;
  logic                      row_bank;
  logic [5:0]                fill_count;
  logic                      overflow;
  logic                      seq_err;

  modport master (
    output data_valid, sel_upper, rdata, row_ready,
    input  row_valid, row_data, row_bank, fill_count, overflow, seq_err
  );

  modport slave (
    input  data_valid, sel_upper, rdata, row_ready,
    output row_valid, row_data, row_bank, fill_count, overflow, seq_err
  );
endinterface

// File: rtl/mat_row_unpack.sv
// Packs half-word elements into ROW_LEN-element rows, ping-pong double-buffered.
// Row presented one cycle after its last element; no upstream backpressure, drops flagged by overflow.
module mat_row_unpack #(
  parameter int ELEM_W  = 16,
  parameter int ROW_LEN = 32
) (
  input logic            clk,
  input logic            rst,
  mat_row_unpack_if.slave bus
);
  localparam int         IDX_W    = $clog2(ROW_LEN);
  localparam logic [5:0] LAST_IDX = 6'(ROW_LEN - 1);

  logic [ELEM_W-1:0] mem [2][ROW_LEN];

  logic              wr_bank;
  logic              rd_bank;
  logic [5:0]        wr_idx;
  logic [1:0]        full;
  logic              overflow_q;
  logic              seq_err_q;

  logic [ELEM_W-1:0] elem;
  logic              drain;
  logic              drain_wr;
  logic              we;
  logic              wr_last;
  logic [1:0]        full_nxt;

  always_comb begin
    elem     = bus.sel_upper ? bus.rdata[2*ELEM_W-1:ELEM_W] : bus.rdata[ELEM_W-1:0];
    drain    = full[rd_bank] & bus.row_ready;
    // A bank being drained this cycle may be refilled immediately.
    drain_wr = drain & (rd_bank == wr_bank);
    we       = bus.data_valid & (~full[wr_bank] | drain_wr);
    wr_last  = (wr_idx == LAST_IDX);
    full_nxt = full;
    if (drain)
      full_nxt[rd_bank] = 1'b0;
    if (we && wr_last)
      full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_idx     <= '0;
      full       <= '0;
      overflow_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      full <= full_nxt;
      if (drain)
        rd_bank <= ~rd_bank;
      if (we) begin
        if (wr_last) begin
          wr_bank <= ~wr_bank;
          wr_idx  <= '0;
        end else begin
          wr_idx  <= wr_idx + 6'd1;
        end
      end
      if (bus.data_valid && !we)
        overflow_q <= 1'b1;
      // Even slots come from the lower half, odd slots from the upper half.
      if (bus.data_valid && (bus.sel_upper != wr_idx[0]))
        seq_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && we)
      mem[wr_bank][wr_idx[IDX_W-1:0]] <= elem;
  end

  for (genvar i = 0; i < ROW_LEN; i++) begin : g_row
    assign bus.row_data[i*ELEM_W +: ELEM_W] = mem[rd_bank][i];
  end

  assign bus.row_valid  = full[rd_bank];
  assign bus.row_bank   = rd_bank;
  assign bus.fill_count = wr_idx;
  assign bus.overflow   = overflow_q;
  assign bus.seq_err    = seq_err_q;
endmodule

// File: tb/tb_mat_row_unpack.sv
// Directed phases with random data, checked each cycle against a queue-based row model.
module tb_mat_row_unpack;
  localparam int ELEM_W  = 16;
  localparam int ROW_LEN = 32;
  localparam int RW      = ROW_LEN * ELEM_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mat_row_unpack_if #(.ELEM_W(ELEM_W), .ROW_LEN(ROW_LEN)) bus ();
  mat_row_unpack #(.ELEM_W(ELEM_W), .ROW_LEN(ROW_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: elements of the row being filled, queue of complete rows
  // awaiting hand-off, count of rows handed off, sticky flags.
  logic [ELEM_W-1:0] partial[$];
  logic [RW-1:0]     rows[$];
  int                drained;
  bit                m_ovf;
  bit                m_serr;

  task automatic chk_s(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_row(string tag, logic [RW-1:0] got, logic [RW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic bit exp_sel();
    return bit'(partial.size() % 2);
  endfunction

  task automatic model_step(bit r, bit dv, bit sel, logic [2*ELEM_W-1:0] rd, bit rdy);
    bit            drain;
    logic [RW-1:0] row;
    if (r) begin
      partial.delete();
      rows.delete();
      drained = 0;
      m_ovf   = 0;
      m_serr  = 0;
      return;
    end
    drain = (rows.size() > 0) && rdy;
    if (dv) begin
      if (sel != exp_sel())
        m_serr = 1;
      if (rows.size() < 2 || drain)
        partial.push_back(sel ? rd[2*ELEM_W-1:ELEM_W] : rd[ELEM_W-1:0]);
      else
        m_ovf = 1;
    end
    if (drain) begin
      void'(rows.pop_front());
      drained++;
    end
    if (partial.size() == ROW_LEN) begin
      row = '0;
      for (int i = 0; i < ROW_LEN; i++)
        row[i*ELEM_W +: ELEM_W] = partial[i];
      rows.push_back(row);
      partial.delete();
    end
  endtask

  task automatic check_all();
    chk_s("row_valid", 64'(bus.row_valid), 64'(rows.size() > 0));
    chk_s("row_bank", 64'(bus.row_bank), 64'(drained % 2));
    chk_s("fill_count", 64'(bus.fill_count), 64'(partial.size()));
    chk_s("overflow", 64'(bus.overflow), 64'(m_ovf));
    chk_s("seq_err", 64'(bus.seq_err), 64'(m_serr));
    if (rows.size() > 0)
      chk_row("row_data", bus.row_data, rows[0]);
  endtask

  task automatic step(bit r, bit dv, bit sel, logic [2*ELEM_W-1:0] rd, bit rdy);
    rst            = r;
    bus.data_valid = dv;
    bus.sel_upper  = sel;
    bus.rdata      = rd;
    bus.row_ready  = rdy;
    model_step(r, dv, sel, rd, rdy);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic feed(int n, bit rdy);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b1, exp_sel(), $urandom, rdy);
  endtask

  initial begin
    rst            = 1'b1;
    bus.data_valid = 1'b0;
    bus.sel_upper  = 1'b0;
    bus.rdata      = '0;
    bus.row_ready  = 1'b0;
    drained        = 0;
    m_ovf          = 0;
    m_serr         = 0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);

    // Basic row: word k = {2k+1, 2k}, element i == i
    for (int k = 0; k < 16; k++)
      for (int h = 0; h < 2; h++)
        step(1'b0, 1'b1, h[0], {16'(2*k + 1), 16'(2*k)}, 1'b1);
    chk_s("basic_elem31", 64'(bus.row_data[31*ELEM_W +: ELEM_W]), 64'd31);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Back-to-back fill, then drain/refill bypass with 0xABCD
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    feed(64, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h5555_ABCD, 1'b1);
    chk_s("bypass_fill", 64'(bus.fill_count), 64'd1);
    // Finish bank 0, then one more element overflows; then hand one row off
    feed(31, 1'b0);
    feed(1, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk_s("bypass_elem0", 64'(bus.row_data[ELEM_W-1:0]), 64'hABCD);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Sequence error on first element; sticky through 40 correct ones
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
    feed(40, 1'b0);
    chk_s("seq_elem0", 64'(bus.row_data[ELEM_W-1:0]), 64'h1234);

    // Reset mid-fill discards everything
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    feed(10, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    feed(32, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Idle gaps: valid every other cycle
    for (int i = 0; i < 64; i++)
      step(1'b0, (i % 2) == 0, exp_sel(), $urandom, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Random traffic with occasional wrong halves
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 400; i++)
      step(1'b0, $urandom_range(0, 3) != 0,
           ($urandom_range(0, 19) == 0) ? ~exp_sel() : exp_sel(),
           $urandom, $urandom_range(0, 2) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
